tick_divider: RTL and testbench

Parametrised multi-channel tick generator; the next generation of the single fixed 1 ms divider. Each of `NCH` channels divides `clk` by a runtime-programmable terminal count and emits both a one-cycle tick pulse and a toggling square wave. The divisor can be reprogrammed glitch-free, with the new value taking effect at the next wrap. It sits between the board clock and the game-logic blocks (paddle scan, ball step, score blink), which run on ticks as clock enables rather than on derived clocks.

---
 rtl/tick_divider_pkg.sv | 15 +
 rtl/tick_channel.sv | 93 +++++++++
 rtl/tick_divider.sv | 43 ++++
 tb/tb_tick_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_divider_pkg.sv
// Shared constants and types for the multi-channel tick divider.
package tick_divider_pkg;

  localparam int DEFAULT_DIV_C = 10;
  localparam int MAX_NCH_C     = 16;
  localparam int DIV_W_C       = 16;

  typedef logic [DIV_W_C-1:0] div_t;

  // div_sel needs at least one bit even for a single channel
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: programmable terminal count, tick pulse and square wave,
// with divisor changes deferred to the next wrap while running.
module tick_channel #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] val,
  output logic             tick,
  output logic             sq
);

  localparam logic [WIDTH-1:0] DEF_DIV_C = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;

  // >= rather than == so a count left above a lowered divisor still wraps
  assign wrap = (cnt_q >= div_act_q);

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;

    if (sync) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      if (wr) begin
        div_act_d = val;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = 1'b0;
      end
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // a write landing on the wrap cycle waits for the following wrap
      if (wr) begin
        div_pend_d = val;
        pend_d     = 1'b1;
      end
    end else if (wr) begin
      div_act_d = val;
      cnt_d     = '0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_act_q  <= DEF_DIV_C;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_divider.sv
// Multi-channel tick generator: decodes divisor writes to NCH tick_channel
// instances that share one clock, reset and sync.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int WIDTH       = 16,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int SELW        = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [SELW-1:0]  div_sel,
  input  logic [WIDTH-1:0] div_val,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  logic [NCH-1:0] wr_ch;

  // selects at or beyond NCH match no channel and are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_ch[i] = div_wr && (div_sel == SELW'(i));

    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en[i]),
      .sync (sync),
      .wr   (wr_ch[i]),
      .val  (div_val),
      .tick (tick[i]),
      .sq   (sq[i])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of the channel rules.
module tb_tick_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  en = '0;
  logic        sync = 1'b0;
  logic        div_wr = 1'b0;
  logic [1:0]  div_sel = '0;
  logic [1:0]  div_sel3 = 2'd3;
  logic [15:0] div_val = '0;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [2:0]  tick3;
  logic [2:0]  sq3;

  int n_checks = 0;
  int n_errors = 0;

  // model slots 0..3 mirror dut, 4..6 mirror dut3
  int m_cnt [7];
  int m_act [7];
  int m_pv  [7];
  bit m_pend[7];
  bit m_tick[7];
  bit m_sq  [7];

  always #5 clk = ~clk;

  tick_divider #(.NCH(4), .WIDTH(16), .DEFAULT_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .tick(tick), .sq(sq)
  );

  tick_divider #(.NCH(3), .WIDTH(16), .DEFAULT_DIV(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en[2:0]), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel3), .div_val(div_val), .tick(tick3), .sq(sq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) begin
      m_cnt[k] = 0; m_act[k] = 10; m_pv[k] = 0;
      m_pend[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
    end
  endtask

  // one rising edge of the specification's channel rules
  task automatic model_step();
    bit run, w;
    for (int k = 0; k < 7; k++) begin
      run = (k < 4) ? en[k] : en[k-4];
      w   = div_wr && ((k < 4) ? (int'(div_sel) == k) : (int'(div_sel3) == k - 4));
      m_tick[k] = 0;
      if (sync) begin
        m_cnt[k] = 0; m_sq[k] = 0;
        if (w) m_act[k] = int'(div_val);
        else if (m_pend[k]) m_act[k] = m_pv[k];
        m_pend[k] = 0;
      end else if (run) begin
        if (m_cnt[k] >= m_act[k]) begin
          m_cnt[k] = 0; m_tick[k] = 1; m_sq[k] = !m_sq[k];
          if (m_pend[k]) begin m_act[k] = m_pv[k]; m_pend[k] = 0; end
        end else m_cnt[k]++;
        if (w) begin m_pv[k] = int'(div_val); m_pend[k] = 1; end
      end else if (w) begin
        m_act[k] = int'(div_val); m_cnt[k] = 0; m_pend[k] = 0;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] et, es;
    logic [2:0] et3, es3;
    for (int k = 0; k < 4; k++) begin et[k] = m_tick[k]; es[k] = m_sq[k]; end
    for (int k = 0; k < 3; k++) begin et3[k] = m_tick[k+4]; es3[k] = m_sq[k+4]; end
    check("tick", 32'(tick), 32'(et));
    check("sq", 32'(sq), 32'(es));
    check("tick_n3", 32'(tick3), 32'(et3));
    check("sq_n3", 32'(sq3), 32'(es3));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic write(input int ch, input int v);
    div_wr = 1'b1; div_sel = 2'(ch); div_val = 16'(v);
    cyc();
    div_wr = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int n);
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      cyc();
      if (tick[ch]) begin n = c; break; end
    end
  endtask

  initial begin
    int n, nt, guard;
    int lat [3];
    bit p;

    model_reset();
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_sq", 32'(sq), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 4'b0001;

    // default divisor: first tick on edge 11, then every 11
    wait_tick(0, 20, n); check("first_tick_n10", n, 11);
    wait_tick(0, 20, n); check("period_n10", n, 11);
    wait_tick(0, 20, n); check("period_n10_b", n, 11);

    // deferred divisor change on a running channel, last write wins
    write(1, 9);
    en[1] = 1'b1;
    guard = 0;
    while (m_cnt[1] != 4 && guard < 30) begin cyc(); guard++; end
    check("ch1_reach_cnt4", m_cnt[1], 4);
    write(1, 3);
    wait_tick(1, 20, n); check("old_n_completes", n, 5);
    wait_tick(1, 20, n); check("new_n3_period", n, 4);
    write(1, 5);
    write(1, 2);
    wait_tick(1, 20, n); check("n3_before_last", n, 2);
    wait_tick(1, 20, n); check("last_write_wins", n, 3);

    // freeze mid-period and resume
    write(2, 7);
    en[2] = 1'b1;
    guard = 0;
    while (m_cnt[2] != 3 && guard < 30) begin cyc(); guard++; end
    en[2] = 1'b0;
    p = m_sq[2];
    nt = 0;
    for (int c = 0; c < 20; c++) begin cyc(); if (tick[2]) nt++; end
    check("frozen_no_tick", nt, 0);
    check("frozen_sq_hold", 32'(sq[2]), 32'(p));
    en[2] = 1'b1;
    wait_tick(2, 20, n); check("resume_latency", n, 5);

    // sync restarts all channels in phase
    en = 4'b0000;
    write(0, 4); write(1, 6); write(2, 9);
    en = 4'b0111;
    repeat (3) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    check("sync_tick_low", 32'(tick), 32'd0);
    check("sync_sq_low", 32'(sq), 32'd0);
    lat = '{-1, -1, -1};
    for (int c = 1; c <= 12; c++) begin
      cyc();
      for (int j = 0; j < 3; j++) if (tick[j] && lat[j] < 0) lat[j] = c;
    end
    check("sync_retick_n4", lat[0], 5);
    check("sync_retick_n6", lat[1], 7);
    check("sync_retick_n9", lat[2], 10);

    // N=0: steady tick and a square wave at half the clock
    write(3, 0);
    en[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      p = m_sq[3];
      cyc();
      check("n0_tick", 32'(tick[3]), 32'd1);
      check("n0_sq_toggle", 32'(sq[3]), 32'(!p));
    end

    // out-of-range select on the three-channel instance
    div_sel3 = 2'd3;
    write(3, 0);
    repeat (25) cyc();

    // async reset with a write pending
    en = 4'b1001;
    write(0, 5);
    repeat (3) cyc();
    write(0, 2);
    cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_sq", 32'(sq), 32'd0);
    check("async_rst_tick_n3", 32'(tick3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 4'b0001;
    wait_tick(0, 20, n); check("post_rst_first", n, 11);
    wait_tick(0, 20, n); check("post_rst_period", n, 11);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      en       = 4'($urandom);
      sync     = ($urandom_range(0, 49) == 0);
      div_wr   = ($urandom_range(0, 5) == 0);
      div_sel  = 2'($urandom);
      div_sel3 = 2'($urandom);
      div_val  = 16'($urandom_range(0, 12));
      cyc();
    end
    div_wr = 1'b0;
    sync   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
